// File: rtl/amo_sequencer_if.sv
// Bundle of the AMO sequencer handshakes: request/response, data-array
// read and write, ALU operands and the lock indication.
interface amo_sequencer_if #(
    parameter int ADDR_W = 40,
    parameter int TAG_W  = 7
);
    logic              io_req_valid;
    logic              io_req_ready;
    logic [ADDR_W-1:0] io_req_addr;
    logic [4:0]        io_req_cmd;
    logic [2:0]        io_req_typ;
    logic [63:0]       io_req_data;
    logic [TAG_W-1:0]  io_req_tag;
    logic              io_kill;

    logic              io_rd_valid;
    logic              io_rd_ready;
    logic [ADDR_W-1:0] io_rd_addr;
    logic              io_rd_resp_valid;
    logic [63:0]       io_rd_resp_data;

    logic [5:0]        io_alu_addr;
    logic [4:0]        io_alu_cmd;
    logic [2:0]        io_alu_typ;
    logic [63:0]       io_alu_lhs;
    logic [63:0]       io_alu_rhs;
    logic [63:0]       io_alu_out;

    logic              io_wr_valid;
    logic              io_wr_ready;
    logic [ADDR_W-1:0] io_wr_addr;
    logic [63:0]       io_wr_data;

    logic              io_resp_valid;
    logic              io_resp_ready;
    logic [TAG_W-1:0]  io_resp_tag;
    logic [63:0]       io_resp_data;

    logic              io_busy;
    logic [ADDR_W-1:0] io_busy_addr;

    // Environment side: pipeline, data array and ALU.
    modport master (
        output io_req_valid, io_req_addr, io_req_cmd, io_req_typ, io_req_data,
               io_req_tag, io_kill, io_rd_ready, io_rd_resp_valid,
               io_rd_resp_data, io_alu_out, io_wr_ready, io_resp_ready,
        input  io_req_ready, io_rd_valid, io_rd_addr, io_alu_addr, io_alu_cmd,
               io_alu_typ, io_alu_lhs, io_alu_rhs, io_wr_valid, io_wr_addr,
               io_wr_data, io_resp_valid, io_resp_tag, io_resp_data,
               io_busy, io_busy_addr
    );

    // Sequencer side.
    modport slave (
        input  io_req_valid, io_req_addr, io_req_cmd, io_req_typ, io_req_data,
               io_req_tag, io_kill, io_rd_ready, io_rd_resp_valid,
               io_rd_resp_data, io_alu_out, io_wr_ready, io_resp_ready,
        output io_req_ready, io_rd_valid, io_rd_addr, io_alu_addr, io_alu_cmd,
               io_alu_typ, io_alu_lhs, io_alu_rhs, io_wr_valid, io_wr_addr,
               io_wr_data, io_resp_valid, io_resp_tag, io_resp_data,
               io_busy, io_busy_addr
    );
endinterface

// File: rtl/amo_sequencer.sv
// Single-outstanding AMO controller: read doubleword, run it through the
// external AMO ALU, write the merged result back, return the old value.
//
// state   | meaning
// IDLE    | ready for a request, busy_addr holds last locked address
// READ    | data-array read requested, kill may abort
// WAIT    | waiting for read data
// CALC    | ALU sees registered operands, result captured at cycle end
// WRITE   | merged doubleword written back
// RESP    | old doubleword returned with the request tag
module amo_sequencer #(
    parameter int ADDR_W = 40,
    parameter int TAG_W  = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    amo_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4,
        S_RESP  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        cmd_q, cmd_d;
    logic [2:0]        typ_q, typ_d;
    logic [63:0]       rhs_q, rhs_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [63:0]       old_q, old_d;
    logic [63:0]       wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cmd_q   <= '0;
            typ_q   <= '0;
            rhs_q   <= '0;
            tag_q   <= '0;
            old_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            typ_q   <= typ_d;
            rhs_q   <= rhs_d;
            tag_q   <= tag_d;
            old_q   <= old_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        typ_d   = typ_q;
        rhs_d   = rhs_q;
        tag_d   = tag_q;
        old_d   = old_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.io_req_valid) begin
                    addr_d  = bus.io_req_addr;
                    cmd_d   = bus.io_req_cmd;
                    typ_d   = bus.io_req_typ;
                    rhs_d   = bus.io_req_data;
                    tag_d   = bus.io_req_tag;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Kill wins over a same-cycle read handshake.
                if (bus.io_kill) begin
                    state_d = S_IDLE;
                end else if (bus.io_rd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.io_rd_resp_valid) begin
                    old_d   = bus.io_rd_resp_data;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                wdata_d = bus.io_alu_out;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.io_wr_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.io_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [ADDR_W-1:0] line_addr;
    assign line_addr = {addr_q[ADDR_W-1:3], 3'b000};

    assign bus.io_req_ready  = (state_q == S_IDLE);
    // A killed READ never presents a read to the array.
    assign bus.io_rd_valid   = (state_q == S_READ) && !bus.io_kill;
    assign bus.io_rd_addr    = line_addr;

    assign bus.io_alu_addr   = addr_q[5:0];
    assign bus.io_alu_cmd    = cmd_q;
    assign bus.io_alu_typ    = typ_q;
    assign bus.io_alu_lhs    = old_q;
    assign bus.io_alu_rhs    = rhs_q;

    assign bus.io_wr_valid   = (state_q == S_WRITE);
    assign bus.io_wr_addr    = line_addr;
    assign bus.io_wr_data    = wdata_q;

    assign bus.io_resp_valid = (state_q == S_RESP);
    assign bus.io_resp_tag   = tag_q;
    assign bus.io_resp_data  = old_q;

    assign bus.io_busy       = (state_q != S_IDLE);
    assign bus.io_busy_addr  = addr_q;
endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: small memory responder, ADD-only ALU
// stand-in, handshake monitor and one task per scenario.
module tb_amo_sequencer;
    localparam int ADDR_W = 40;
    localparam int TAG_W  = 7;
    localparam logic [4:0] M_XA_ADD = 5'b01000;
    localparam logic [2:0] MT_W     = 3'b010;
    localparam logic [2:0] MT_D     = 3'b011;

    logic clk;
    logic rst_n;
    amo_sequencer_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

    amo_sequencer #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [63:0] alu_model(input logic [63:0] lhs, input logic [63:0] rhs,
                                              input logic upper, input logic [2:0] typ);
        logic [31:0] w;
        logic [31:0] s;
        if (typ == MT_W) begin
            w = upper ? lhs[63:32] : lhs[31:0];
            s = w + rhs[31:0];
            return upper ? {s, lhs[31:0]} : {lhs[63:32], s};
        end
        return lhs + rhs;
    endfunction

    assign bus.io_alu_out = alu_model(bus.io_alu_lhs, bus.io_alu_rhs, bus.io_alu_addr[2], bus.io_alu_typ);

    // Handshake monitor, samples pre-edge values.
    int cyc = 0;
    int acc_cnt = 0, rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
    int acc_cyc = 0, resp_cyc = 0;
    logic [ADDR_W-1:0] acc_busy_addr = '0, last_rd_addr = '0, last_wr_addr = '0;
    logic [63:0] last_wr_data = '0, last_resp_data = '0;
    logic [TAG_W-1:0] last_resp_tag = '0;

    always @(posedge clk) begin
        if (bus.io_req_valid && bus.io_req_ready && rst_n) begin
            acc_cnt       <= acc_cnt + 1;
            acc_cyc       <= cyc;
            acc_busy_addr <= bus.io_busy_addr;
        end
        if (bus.io_rd_valid && bus.io_rd_ready) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= bus.io_rd_addr;
        end
        if (bus.io_wr_valid && bus.io_wr_ready) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.io_wr_addr;
            last_wr_data <= bus.io_wr_data;
        end
        if (bus.io_resp_valid && bus.io_resp_ready) begin
            resp_cnt       <= resp_cnt + 1;
            resp_cyc       <= cyc;
            last_resp_data <= bus.io_resp_data;
            last_resp_tag  <= bus.io_resp_tag;
        end
        cyc <= cyc + 1;
    end

    // Memory: returns mem_word one cycle after each read handshake.
    logic [63:0] mem_word = '0;
    int rd_served = 0;
    always @(negedge clk) begin
        if (rd_cnt != rd_served) begin
            bus.io_rd_resp_valid = 1'b1;
            bus.io_rd_resp_data  = mem_word;
            rd_served            = rd_cnt;
        end else begin
            bus.io_rd_resp_valid = 1'b0;
            bus.io_rd_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    task automatic set_req(input logic [ADDR_W-1:0] addr, input logic [2:0] typ,
                           input logic [63:0] rhs, input logic [TAG_W-1:0] tag);
        bus.io_req_addr = addr;
        bus.io_req_cmd  = M_XA_ADD;
        bus.io_req_typ  = typ;
        bus.io_req_data = rhs;
        bus.io_req_tag  = tag;
    endtask

    task automatic wait_acc(input string name);
        int a0 = acc_cnt;
        int k = 0;
        while (acc_cnt == a0 && k < 30) begin @(negedge clk); k++; end
        n_checks++;
        if (acc_cnt == a0) begin
            n_errors++;
            $display("FAIL %s_accept_timeout: no accept after %0d cycles, required 1", name, k);
        end
    endtask

    task automatic wait_resp(input string name);
        int r0 = resp_cnt;
        int k = 0;
        while (resp_cnt == r0 && k < 60) begin @(negedge clk); k++; end
        n_checks++;
        if (resp_cnt == r0) begin
            n_errors++;
            $display("FAIL %s_resp_timeout: no response after %0d cycles, required 1", name, k);
        end
    endtask

    task automatic do_op(input string name, input logic [ADDR_W-1:0] addr, input logic [2:0] typ,
                         input logic [63:0] rhs, input logic [TAG_W-1:0] tag, input logic [63:0] mem);
        @(negedge clk);
        mem_word = mem;
        set_req(addr, typ, rhs, tag);
        bus.io_req_valid = 1'b1;
        wait_acc(name);
        bus.io_req_valid = 1'b0;
        wait_resp(name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.io_req_valid = 1'b0;
        bus.io_kill = 1'b0;
        bus.io_rd_ready = 1'b1;
        bus.io_wr_ready = 1'b1;
        bus.io_resp_ready = 1'b1;
        set_req('0, MT_D, '0, '0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.io_req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_req_ready: got %b exp 1", bus.io_req_ready); end
        n_checks++; if ({bus.io_rd_valid, bus.io_wr_valid, bus.io_resp_valid, bus.io_busy} !== 4'b0000) begin
            n_errors++; $display("FAIL rst_valids: got %b exp 0000", {bus.io_rd_valid, bus.io_wr_valid, bus.io_resp_valid, bus.io_busy}); end
        n_checks++; if (bus.io_busy_addr !== '0 || bus.io_rd_addr !== '0) begin
            n_errors++; $display("FAIL rst_addr: got busy %h rd %h exp 0", bus.io_busy_addr, bus.io_rd_addr); end
        n_checks++; if (bus.io_alu_lhs !== 64'h0 || bus.io_alu_rhs !== 64'h0 || bus.io_wr_data !== 64'h0 || bus.io_resp_tag !== '0) begin
            n_errors++; $display("FAIL rst_data: got lhs %h rhs %h wd %h tag %h exp 0", bus.io_alu_lhs, bus.io_alu_rhs, bus.io_wr_data, bus.io_resp_tag); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_amoadd_d;
        int w0 = wr_cnt;
        do_op("add_d", 40'h1000, MT_D, 64'h3, 7'h15, 64'h5);
        n_checks++; if (wr_cnt - w0 !== 1) begin n_errors++; $display("FAIL add_d_wr_count: got %0d exp 1", wr_cnt - w0); end
        n_checks++; if (last_rd_addr !== 40'h1000) begin n_errors++; $display("FAIL add_d_rd_addr: got %h exp 1000", last_rd_addr); end
        n_checks++; if (last_wr_addr !== 40'h1000 || last_wr_data !== 64'h8) begin
            n_errors++; $display("FAIL add_d_write: got %h@%h exp 8@1000", last_wr_data, last_wr_addr); end
        n_checks++; if (last_resp_data !== 64'h5 || last_resp_tag !== 7'h15) begin
            n_errors++; $display("FAIL add_d_resp: got %h tag %h exp 5 tag 15", last_resp_data, last_resp_tag); end
        n_checks++; if (resp_cyc - acc_cyc !== 5) begin n_errors++; $display("FAIL add_d_occupancy: got %0d exp 5", resp_cyc - acc_cyc); end
        n_checks++; if (bus.io_busy !== 1'b0 || bus.io_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL add_d_idle: got busy %b ready %b exp 0 1", bus.io_busy, bus.io_req_ready); end
        n_checks++; if (bus.io_alu_cmd !== M_XA_ADD || bus.io_alu_typ !== MT_D || bus.io_busy_addr !== 40'h1000) begin
            n_errors++; $display("FAIL add_d_latched: got cmd %h typ %h baddr %h exp 08 3 1000", bus.io_alu_cmd, bus.io_alu_typ, bus.io_busy_addr); end
    endtask

    task automatic test_amoadd_w_upper;
        do_op("add_w", 40'h1004, MT_W, 64'h1, 7'h2A, 64'h0000_0001_FFFF_FFFF);
        n_checks++; if (last_wr_addr !== 40'h1000 || last_wr_data !== 64'h0000_0002_FFFF_FFFF) begin
            n_errors++; $display("FAIL add_w_write: got %h@%h exp 00000002ffffffff@1000", last_wr_data, last_wr_addr); end
        n_checks++; if (last_resp_data !== 64'h0000_0001_FFFF_FFFF || last_resp_tag !== 7'h2A) begin
            n_errors++; $display("FAIL add_w_resp: got %h tag %h exp 00000001ffffffff tag 2a", last_resp_data, last_resp_tag); end
        n_checks++; if (bus.io_alu_addr !== 6'h04 || bus.io_busy_addr !== 40'h1004) begin
            n_errors++; $display("FAIL add_w_addr: got alu %h busy %h exp 04 1004", bus.io_alu_addr, bus.io_busy_addr); end
    endtask

    task automatic test_backpressure;
        int w0 = wr_cnt;
        int r0 = resp_cnt;
        int k;
        @(negedge clk);
        mem_word = 64'h23;
        set_req(40'h4013, MT_D, 64'h100, 7'h7F);
        bus.io_rd_ready = 1'b0;
        bus.io_wr_ready = 1'b0;
        bus.io_resp_ready = 1'b0;
        bus.io_req_valid = 1'b1;
        wait_acc("bp");
        bus.io_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.io_rd_valid !== 1'b1 || bus.io_rd_addr !== 40'h4010) begin
                n_errors++; $display("FAIL bp_rd_hold%0d: got %b %h exp 1 4010", i, bus.io_rd_valid, bus.io_rd_addr); end
            @(negedge clk);
        end
        bus.io_rd_ready = 1'b1;
        k = 0;
        while (bus.io_wr_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.io_wr_valid !== 1'b1 || bus.io_wr_addr !== 40'h4010 || bus.io_wr_data !== 64'h123) begin
                n_errors++; $display("FAIL bp_wr_hold%0d: got %b %h@%h exp 1 123@4010", i, bus.io_wr_valid, bus.io_wr_data, bus.io_wr_addr); end
            @(negedge clk);
        end
        bus.io_wr_ready = 1'b1;
        k = 0;
        while (bus.io_resp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.io_resp_valid !== 1'b1 || bus.io_resp_data !== 64'h23 || bus.io_resp_tag !== 7'h7F) begin
                n_errors++; $display("FAIL bp_resp_hold%0d: got %b %h tag %h exp 1 23 tag 7f", i, bus.io_resp_valid, bus.io_resp_data, bus.io_resp_tag); end
            @(negedge clk);
        end
        bus.io_resp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (wr_cnt - w0 !== 1 || resp_cnt - r0 !== 1) begin
            n_errors++; $display("FAIL bp_counts: got wr %0d resp %0d exp 1 1", wr_cnt - w0, resp_cnt - r0); end
        n_checks++; if (bus.io_busy !== 1'b0) begin n_errors++; $display("FAIL bp_idle: got busy %b exp 0", bus.io_busy); end
    endtask

    task automatic test_kill;
        int rd0 = rd_cnt;
        int w0 = wr_cnt;
        int r0 = resp_cnt;
        @(negedge clk);
        set_req(40'h5000, MT_D, 64'h1, 7'h33);
        bus.io_req_valid = 1'b1;
        wait_acc("kill");
        bus.io_req_valid = 1'b0;
        bus.io_kill = 1'b1;
        bus.io_rd_ready = 1'b1;
        @(negedge clk);
        bus.io_kill = 1'b0;
        n_checks++; if (bus.io_busy !== 1'b0 || bus.io_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL kill_idle: got busy %b ready %b exp 0 1", bus.io_busy, bus.io_req_ready); end
        repeat (8) @(negedge clk);
        n_checks++; if (rd_cnt != rd0 || wr_cnt != w0 || resp_cnt != r0) begin
            n_errors++; $display("FAIL kill_no_traffic: got rd %0d wr %0d resp %0d exp 0 0 0", rd_cnt - rd0, wr_cnt - w0, resp_cnt - r0); end
    endtask

    task automatic test_back_to_back;
        int a1;
        int a2;
        @(negedge clk);
        mem_word = 64'h10;
        set_req(40'h2000, MT_D, 64'h1, 7'h01);
        bus.io_req_valid = 1'b1;
        wait_acc("b2b_first");
        a1 = acc_cyc;
        set_req(40'h3008, MT_D, 64'h2, 7'h02);
        n_checks++; if (bus.io_req_ready !== 1'b0 || bus.io_busy_addr !== 40'h2000) begin
            n_errors++; $display("FAIL b2b_busy_first: got ready %b baddr %h exp 0 2000", bus.io_req_ready, bus.io_busy_addr); end
        wait_acc("b2b_second");
        a2 = acc_cyc;
        bus.io_req_valid = 1'b0;
        n_checks++; if (a2 - a1 !== 6) begin n_errors++; $display("FAIL b2b_spacing: got %0d exp 6", a2 - a1); end
        n_checks++; if (acc_busy_addr !== 40'h2000 || bus.io_busy_addr !== 40'h3008) begin
            n_errors++; $display("FAIL b2b_busy_addr: got T6 %h T7 %h exp 2000 3008", acc_busy_addr, bus.io_busy_addr); end
        n_checks++; if (last_wr_data !== 64'h11 || last_wr_addr !== 40'h2000) begin
            n_errors++; $display("FAIL b2b_first_write: got %h@%h exp 11@2000", last_wr_data, last_wr_addr); end
        wait_resp("b2b");
        n_checks++; if (last_wr_data !== 64'h12 || last_wr_addr !== 40'h3008 || last_resp_tag !== 7'h02 || last_resp_data !== 64'h10) begin
            n_errors++; $display("FAIL b2b_second: got %h@%h tag %h old %h exp 12@3008 tag 02 old 10", last_wr_data, last_wr_addr, last_resp_tag, last_resp_data); end
    endtask

    task automatic test_reset_in_write;
        int w0;
        int r0;
        int k;
        @(negedge clk);
        mem_word = 64'h40;
        set_req(40'h6000, MT_D, 64'h4, 7'h44);
        bus.io_wr_ready = 1'b0;
        bus.io_req_valid = 1'b1;
        wait_acc("rstw");
        bus.io_req_valid = 1'b0;
        k = 0;
        while (bus.io_wr_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (bus.io_wr_valid !== 1'b1) begin n_errors++; $display("FAIL rstw_reach_write: got %b exp 1", bus.io_wr_valid); end
        w0 = wr_cnt;
        r0 = resp_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.io_wr_valid, bus.io_busy, bus.io_resp_valid} !== 3'b000 || bus.io_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL rstw_async: got wr/busy/resp %b ready %b exp 000 1", {bus.io_wr_valid, bus.io_busy, bus.io_resp_valid}, bus.io_req_ready); end
        bus.io_wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt != w0 || resp_cnt != r0 || bus.io_busy_addr !== '0) begin
            n_errors++; $display("FAIL rstw_abandon: got wr %0d resp %0d baddr %h exp 0 0 0", wr_cnt - w0, resp_cnt - r0, bus.io_busy_addr); end
        do_op("rstw_fresh", 40'h1000, MT_D, 64'h3, 7'h05, 64'h5);
        n_checks++; if (last_wr_data !== 64'h8 || last_wr_addr !== 40'h1000 || last_resp_data !== 64'h5 || last_resp_tag !== 7'h05) begin
            n_errors++; $display("FAIL rstw_fresh: got %h@%h old %h tag %h exp 8@1000 old 5 tag 05", last_wr_data, last_wr_addr, last_resp_data, last_resp_tag); end
    endtask

    initial begin
        test_reset();
        test_amoadd_d();
        test_amoadd_w_upper();
        test_backpressure();
        test_kill();
        test_back_to_back();
        test_reset_in_write();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/amo_sequencer.md
# amo_sequencer

Multi-cycle controller that executes one atomic memory operation at a time for the non-blocking data cache. It accepts an AMO request from the s2/s3 pipeline and reads the target doubleword from the data array. It then drives the combinational AMO ALU (`mprcAMOALU`) with the read data and request operands, writes the merged result back, and returns the pre-operation doubleword to the requester. While busy it publishes the locked address so other stages can stall on a conflict.

## Interface
- `ADDR_W`, default 40: physical address width.
- `TAG_W`, default 7: request tag width.
- Data width is fixed at 64 to match the ALU.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_req_valid` in 1, `io_req_ready` out 1: AMO request handshake.
- `io_req_addr` in ADDR_W: byte address.
- `io_req_cmd` in 5: M_XA_* command.
- `io_req_typ` in 3: MT_* size/sign.
- `io_req_data` in 64: rhs operand.
- `io_req_tag` in TAG_W: returned with the response.
- `io_kill` in 1: abort, honoured only in READ.
- `io_rd_valid` out 1, `io_rd_ready` in 1: data-array read request.
- `io_rd_addr` out ADDR_W: `{addr[ADDR_W-1:3],3'b0}`.
- `io_rd_resp_valid` in 1, `io_rd_resp_data` in 64: read return.
- `io_alu_addr` out 6, `io_alu_cmd` out 5, `io_alu_typ` out 3, `io_alu_lhs` out 64, `io_alu_rhs` out 64: ALU operands.
- `io_alu_out` in 64: ALU merged result.
- `io_wr_valid` out 1, `io_wr_ready` in 1, `io_wr_addr` out ADDR_W, `io_wr_data` out 64: data-array write.
- `io_resp_valid` out 1, `io_resp_ready` in 1, `io_resp_tag` out TAG_W, `io_resp_data` out 64: old doubleword, unshifted and unextended.
- `io_busy` out 1, `io_busy_addr` out ADDR_W: lock indication.

## Operation
- **States:** IDLE, READ, WAIT, CALC, WRITE, RESP; one-hot or binary encoding is free.
- **IDLE:**
  - `io_req_ready`=1.
  - On `io_req_valid&io_req_ready`, latch addr/cmd/typ/data/tag and go to READ.
- **READ:**
  - `io_rd_valid`=1; `io_rd_addr` is held stable until `io_rd_ready`, then go to WAIT.
  - If `io_kill`=1 go to IDLE. No read is issued and no response is produced.
  - Kill takes priority over a same-cycle `io_rd_ready`.
- **WAIT:**
  - On `io_rd_resp_valid`, latch `io_rd_resp_data` into the old-data register and go to CALC.
  - `io_rd_resp_valid` in any other state is ignored.
- **CALC:**
  - ALU inputs come from registers only: `io_alu_lhs`=old-data register, `io_alu_rhs`=latched req data, `io_alu_addr`=latched addr[5:0], `io_alu_cmd`/`io_alu_typ`=latched.
  - At the end of the cycle, register `io_alu_out` into the write-data register and go to WRITE.
- **WRITE:**
  - `io_wr_valid`=1 with `io_wr_addr`=`io_rd_addr` value and `io_wr_data`=the write-data register.
  - Go to RESP on `io_wr_ready`.
- **RESP:**
  - `io_resp_valid`=1 with `io_resp_data`=old-data register and `io_resp_tag`=latched tag.
  - Go to IDLE on `io_resp_ready`.
- **Busy:**
  - `io_busy`=1 in every state except IDLE.
  - `io_busy_addr`=latched addr in every state, including IDLE, where it holds the last value.
- **ALU outputs:** driven from registers in all states; the ALU result is consumed only in CALC.
- **Commands:** any 5-bit command is passed through unchanged. Non-AMO or swap semantics are resolved by the ALU.

## Timing
- **Reset (async, `rst_n`=0):**
  - State is IDLE, so `io_req_ready`=1 combinationally.
  - All other valid/busy outputs are 0.
  - All data, address and tag registers are 0.
- **Reset deassertion:** no request is accepted in the cycle `rst_n` rises; acceptance is permitted from the next rising edge.
- **Reset mid-operation:** the operation is abandoned in any state. No write and no response follow, even if a write handshake was pending.
- **Minimum occupancy, all handshakes immediate and read data one cycle after the read handshake:**
  - T0 accept.
  - T1 read fires.
  - T2 rd_resp.
  - T3 CALC.
  - T4 write fires.
  - T5 resp fires.
  - T6 IDLE, next accept possible.
- **Handshakes:** every valid is held, with its payload stable, until its matching ready. Valids never depend combinationally on readies.
- **Overlap:** at most one operation is in flight. `io_req_ready`=0 outside IDLE. No same-cycle accept on the RESP exit.

## Test plan
- **AMOADD.D** (cmd M_XA_ADD, typ MT_D, addr 0x1000): memory 0x5, rhs 0x3 -> write 0x8 to 0x1000; response 0x5 with the request tag; occupancy 6 cycles.
- **AMOADD.W upper word** (addr 0x1004): memory 0x00000001_FFFFFFFF, rhs 0x1 -> write 0x00000002_FFFFFFFF; response 0x00000001_FFFFFFFF.
- **Backpressure:** `io_rd_ready`, `io_wr_ready` and `io_resp_ready` each low for 3 cycles -> the corresponding valid and payload are stable throughout; exactly one write and one response occur.
- **Kill:** `io_kill`=1 together with `io_rd_ready`=1 in READ -> no `io_rd_valid` handshake counted, no write, no response; `io_busy` drops next cycle and `io_req_ready`=1.
- **Back-to-back:** two requests with `io_req_valid` held high -> second accepted exactly at T6; `io_busy_addr` changes from the first to the second address at T7.
- **Reset in WRITE:** assert `rst_n`=0 while `io_wr_valid`=1 and `io_wr_ready`=0 -> `io_wr_valid`, `io_busy` and `io_resp_valid` fall immediately (asynchronously); after release, a fresh AMOADD.D completes correctly.
